// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encodings and small op-decoding helpers.
package mdu_iter_pkg;

  localparam int MDU_OP_WIDTH = 3;

  // RISC-V funct3 encoding of the M-extension ops
  typedef enum logic [MDU_OP_WIDTH-1:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  // Width of the full product / accumulator for a given XLEN
  function automatic int cpu_double_width(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL is treated as signed: the low half of the product is the same
  // either way, and it keeps the sign rule uniform with MULH.
  function automatic logic src1_signed(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic src2_signed(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            bit_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // Trial subtraction; the top bit of the difference is the borrow
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    q_o     = ~diff[XLEN+1];
    rem_o   = q_o ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit. Operands are reduced to
// magnitudes on acceptance, iterated in CALC, sign-corrected in NEG and
// presented for one cycle in DONE.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int MUL_BITS_PER_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
  input  logic [XLEN-1:0]         src1_i,
  input  logic [XLEN-1:0]         src2_i,
  input  logic                    flush_i,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    valid_o,
  output logic [XLEN-1:0]         result_o
);

  localparam int CPU_DOUBLE_WIDTH = cpu_double_width(XLEN);
  localparam int DW = CPU_DOUBLE_WIDTH;
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BITS_PER_CYC - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d;
  logic            sign_q, sign_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;

  mdu_op_e         op_in;
  logic            s1_neg, s2_neg, sign_in;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;
  logic [DW:0]     mul_acc;
  logic [XLEN:0]   step_rem;
  logic            step_q;
  logic [DW-1:0]   prod_signed;
  logic [XLEN-1:0] div_field;
  logic [XLEN-1:0] res_field;
  logic [CW-1:0]   cnt_last;

  // Decode the incoming request: magnitudes, result sign and special cases
  always_comb begin
    op_in    = mdu_op_e'(mdu_op_i);
    s1_neg   = src1_signed(op_in) & src1_i[XLEN-1];
    s2_neg   = src2_signed(op_in) & src2_i[XLEN-1];
    mag1     = s1_neg ? -src1_i : src1_i;
    mag2     = s2_neg ? -src2_i : src2_i;
    sign_in  = op_is_rem(op_in) ? s1_neg : (s1_neg ^ s2_neg);
    div_zero = op_is_div(op_in) && (src2_i == '0);
    div_ovf  = op_is_div(op_in) && src1_signed(op_in) &&
               (src1_i == MIN_NEG) && (src2_i == '1);
  end

  // Shift-add multiplier step retiring MUL_BITS_PER_CYC multiplier bits
  always_comb begin
    mul_acc = {1'b0, acc_q};
    for (int i = 0; i < MUL_BITS_PER_CYC; i++) begin
      if (mul_acc[0]) begin
        mul_acc[DW:XLEN] = mul_acc[DW:XLEN] + {1'b0, opb_q};
      end
      mul_acc = mul_acc >> 1;
    end
  end

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (rem_q),
    .divisor_i (opb_q),
    .bit_i     (acc_q[XLEN-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Sign correction and result field selection used in NEG
  always_comb begin
    prod_signed = sign_q ? -acc_q : acc_q;
    div_field   = op_is_rem(op_q) ? rem_q[XLEN-1:0] : acc_q[XLEN-1:0];
    cnt_last    = op_is_div(op_q) ? DIV_LAST : MUL_LAST;
    case (op_q)
      MDU_MUL:                          res_field = prod_signed[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  res_field = prod_signed[DW-1:XLEN];
      default:                          res_field = sign_q ? -div_field : div_field;
    endcase
  end

  // Next-state logic for the FSM and the datapath registers
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    valid_d  = 1'b0;
    result_d = result_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_d   = op_in;
            sign_d = sign_in;
            cnt_d  = '0;
            rem_d  = '0;
            if (op_is_div(op_in)) begin
              opb_d = mag2;
              acc_d = {{XLEN{1'b0}}, mag1};
            end else begin
              opb_d = mag1;
              acc_d = {{XLEN{1'b0}}, mag2};
            end
            if (div_zero) begin
              res_d   = op_is_rem(op_in) ? src1_i : '1;
              state_d = S_DONE;
            end else if (div_ovf) begin
              res_d   = op_is_rem(op_in) ? '0 : src1_i;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_is_div(op_q)) begin
            acc_d = {acc_q[DW-1:XLEN], acc_q[XLEN-2:0], step_q};
            rem_d = step_rem;
          end else begin
            acc_d = mul_acc[DW-1:0];
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == cnt_last) begin
            state_d = S_NEG;
          end
        end
        S_NEG: begin
          res_d   = res_field;
          state_d = S_DONE;
        end
        S_DONE: begin
          valid_d  = 1'b1;
          result_d = res_q;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= MDU_MUL;
      sign_q   <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32, MUL_BITS_PER_CYC=2): directed
// vector table, flush and reset sequences, then random ops against a model.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  mdu_op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        flush_i;
  logic        ready_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.XLEN(32), .MUL_BITS_PER_CYC(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .mdu_op_i (mdu_op_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Architectural result of an M-extension op, straight from the ISA rules
  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    case (op)
      3'b000: begin p = ea * eb; return p[31:0]; end
      3'b001: begin p = ea * eb; return p[63:32]; end
      3'b010: begin eb = {32'd0, b}; p = ea * eb; return p[63:32]; end
      3'b011: begin ea = {32'd0, a}; eb = {32'd0, b}; p = ea * eb; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Edges from acceptance to the edge after which valid_o is high
  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return op[2] ? 34 : 18;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op and wait (bounded) for its valid_o pulse
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output int lat, output bit busy_ok);
    @(negedge clk);
    mdu_op_i = op;
    src1_i   = a;
    src2_i   = b;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    src1_i  = $urandom;
    src2_i  = $urandom;
    busy_ok = busy_o;
    lat     = -1;
    res     = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        lat = c;
        res = result_o;
        break;
      end
      if (!busy_o) busy_ok = 1'b0;
    end
  endtask

  vec_t        vecs[12];
  logic [31:0] res;
  logic [31:0] prior;
  int          lat;
  bit          busy_ok;
  int          vcount;
  logic [31:0] corners[6];

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 18};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 18};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 18};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 18};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{3'b101, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[8]  = '{3'b110, 32'd5,          32'd0,         32'd5,         1};
    vecs[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[11] = '{3'b111, 32'd23,         32'd5,         32'd3,         34};
    corners  = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};

    rst_n    = 1'b0;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    mdu_op_i = 3'b000;
    src1_i   = '0;
    src2_i   = '0;
    #12;
    checkOutput("reset ready", ready_o, 1);
    checkOutput("reset busy", busy_o, 0);
    checkOutput("reset valid", valid_o, 0);
    checkOutput("reset result", result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy_ok);
      checkOutput($sformatf("vec%0d result", i), res, vecs[i].exp);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d busy", i), busy_ok, 1);
    end
    @(posedge clk);
    #1;
    checkOutput("valid one-cycle pulse", valid_o, 0);
    checkOutput("result held", result_o, 32'd3);

    $display("[TB] flush during divide");
    prior = result_o;
    @(negedge clk);
    mdu_op_i = 3'b100;
    src1_i   = 32'd1000;
    src2_i   = 32'd3;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("busy before flush", busy_o, 1);
    flush_i  = 1'b1;
    start_i  = 1'b1;
    mdu_op_i = 3'b000;
    src1_i   = 32'd5;
    src2_i   = 32'd6;
    @(posedge clk);
    #1;
    checkOutput("flush ready", ready_o, 1);
    checkOutput("flush valid", valid_o, 0);
    checkOutput("flush result kept", result_o, prior);
    flush_i = 1'b0;
    start_i = 1'b0;
    vcount  = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (valid_o) vcount++;
    end
    checkOutput("no valid after flush", vcount, 0);
    checkOutput("result after flush", result_o, prior);
    applyStimulus(3'b000, 32'd3, 32'd4, res, lat, busy_ok);
    checkOutput("mul after flush", res, 32'd12);
    checkOutput("mul after flush latency", lat, 18);

    $display("[TB] reset during CALC");
    @(negedge clk);
    mdu_op_i = 3'b101;
    src1_i   = 32'd77;
    src2_i   = 32'd5;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    checkOutput("busy before reset", busy_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", busy_o, 0);
    checkOutput("async reset ready", ready_o, 1);
    checkOutput("async reset result", result_o, 0);
    checkOutput("async reset valid", valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b101, 32'd9, 32'd3, res, lat, busy_ok);
    checkOutput("divu after reset", res, 32'd3);
    checkOutput("divu after reset latency", lat, 34);

    $display("[TB] random ops against model");
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      applyStimulus(op, a, b, res, lat, busy_ok);
      checkOutput($sformatf("rand%0d op%0d %h,%h", n, op, a, b), res, ref_model(op, a, b));
      checkOutput($sformatf("rand%0d latency", n), lat, ref_latency(op, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit implementing the full RV32M/RV64M operation set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It is parametrised in data width and multiplier radix, and owns its own divider datapath. It sits beside `alu_core` in the execute stage. The execute-stage selector routes M-extension ops here and stalls the pipeline while `busy_o` is high. It replaces the ALU's inline single-cycle multiply and its external-divider handshake.

## Interface
- `XLEN`, 32: operand and result width. Must be 32 or 64.
- `MUL_BITS_PER_CYC`, 2: multiplier bits retired per cycle. Must be 1, 2 or 4, and must divide `XLEN`.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_i` input 1: request. Sampled only when `ready_o`=1.
- `mdu_op_i` input 3: operation, RISC-V funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `src1_i` input `XLEN`: rs1 operand (multiplicand / dividend).
- `src2_i` input `XLEN`: rs2 operand (multiplier / divisor).
- `flush_i` input 1: abort any operation in flight.
- `ready_o` output 1: unit idle and able to accept `start_i`.
- `busy_o` output 1: operation in flight; drives the pipeline stall.
- `valid_o` output 1: one-cycle pulse marking `result_o` valid.
- `result_o` output `XLEN`: result. Holds its value until the next `valid_o`.

## Operation
- FSM states: IDLE, CALC, NEG, DONE.
- Reset values: state IDLE, `ready_o`=1, `busy_o`=0, `valid_o`=0, `result_o`=0, all internal registers 0.
- IDLE, `start_i`=1 and `flush_i`=0 latch the following:
  - the op;
  - operand magnitudes: two's-complement absolute value for signed operands (MULH: both; MULHSU: src1 only; DIV/REM: both);
  - the result sign: MUL/MULH/MULHSU/DIV use s1^s2; REM uses the sign of src1; unsigned ops use 0.
- Special cases, detected in IDLE, go directly to DONE and skip CALC:
  - divide-by-zero: quotient = all ones, remainder = `src1_i`;
  - signed overflow (src1 = -2^(XLEN-1), src2 = -1): quotient = `src1_i`, remainder = 0.
- Multiply in CALC:
  - shift-add over a 2·`XLEN` accumulator;
  - each cycle retires `MUL_BITS_PER_CYC` multiplier bits;
  - N = `XLEN`/`MUL_BITS_PER_CYC` cycles.
- Divide in CALC:
  - radix-2 restoring, one quotient bit per cycle;
  - N = `XLEN` cycles;
  - `XLEN`+1-bit partial remainder.
- Iteration counter: width clog2(`XLEN`)+1. CALC exits when it reaches N-1.
- NEG: one cycle. Two's-complements the selected result field if the result sign is 1, otherwise passes it through.
- Result field selection:
  - MUL takes the low `XLEN` bits;
  - MULH/MULHSU/MULHU take the high `XLEN` bits of the 2·`XLEN` product, taken after negation;
  - DIV/DIVU take the quotient;
  - REM/REMU take the remainder.
- DONE: `valid_o`=1 and `result_o` is updated, then the FSM returns to IDLE.
- `flush_i`=1 in any state returns the FSM to IDLE on the next edge:
  - no `valid_o`;
  - `result_o` unchanged.
  - Flush and `start_i` in the same cycle: flush wins and the start is dropped.
- `start_i` outside IDLE is ignored. It is not queued.

## Timing
- `ready_o` = (state==IDLE). `busy_o` = (state!=IDLE).
- With `start_i` sampled at edge T, `valid_o` is high in the cycle following:
  - special cases: edge T+1;
  - multiply: edge T+N+2 (`XLEN`=32, `MUL_BITS_PER_CYC`=2 gives T+18);
  - divide: edge T+`XLEN`+2 (T+34).
- Back-to-back throughput: the next start is accepted in the cycle after DONE.
- `rst_n` low mid-operation forces every output to its reset value immediately, without waiting for a clock edge.
- Operands are registered at acceptance, so `src1_i`/`src2_i` may change freely afterwards.

## Structure
- The shared defines file gains:
  - `MDU_OP_WIDTH` and the eight `MDU_*` op codes;
  - the FSM state encodings;
  - `CPU_DOUBLE_WIDTH` derived from `XLEN`.
- Sub-module `mdu_div_step`: combinational single restoring step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder and quotient bit.
  - Instantiated once; reused every cycle.
- The shift-add multiplier step stays inline and is generated over `MUL_BITS_PER_CYC`.

## Test plan
All scenarios use `XLEN`=32 and `MUL_BITS_PER_CYC`=2.
- MUL, src1=7, src2=0xFFFFFFFD (-3) -> `result_o`=0xFFFFFFEB, `valid_o` exactly 18 cycles after start, `busy_o` high throughout.
- MULH, 0x80000000 × 0x80000000 -> 0x40000000; MULHSU, 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF; MULHU on the same operands -> 0xFFFFFFFE.
- DIV, src1=0xFFFFFFF9 (-7), src2=2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU, 100/7 -> 14 at T+34.
- DIVU x/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 — each with `valid_o` one cycle after start.
- Flush on cycle 10 of a DIV, with a concurrent `start_i` -> no `valid_o`; `ready_o`=1 next cycle; `result_o` keeps its prior value; the next MUL 3×4 returns 12.
- Assert `rst_n`=0 during CALC -> `busy_o`=0, `ready_o`=1, `result_o`=0 without a clock edge; after release, DIVU 9/3 -> 3.
